// File: rtl/load_replay_scheduler_pkg.sv
// Shared load/store definitions: replay-entry layout and the ROB age compare
// used by both the replay scheduler and the load issue banks.
package load_replay_scheduler_pkg;

  localparam int LSU_PIPELINES  = 2;
  localparam int LSU_BANK_WIDTH = 4;
  localparam int LSU_MSHR_WIDTH = 2;
  localparam int LSU_ROB_WIDTH  = 5;
  localparam int LSU_BANK_SEL_W = (LSU_PIPELINES > 1) ? $clog2(LSU_PIPELINES) : 1;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } ReplayState;

  typedef logic [LSU_ROB_WIDTH:0] rob_ptr_t;

  typedef struct packed {
    ReplayState                state;
    logic [LSU_BANK_SEL_W-1:0] bank;
    logic [LSU_BANK_WIDTH-1:0] issue_idx;
    logic [LSU_MSHR_WIDTH-1:0] mshr;
    rob_ptr_t                  rob;
  } ReplayEntry;

  // {dir, idx} pointers: a differing dir bit means the ROB index has wrapped
  function automatic logic rob_older(input rob_ptr_t rob, input rob_ptr_t ref_rob);
    return (rob[LSU_ROB_WIDTH] ^ ref_rob[LSU_ROB_WIDTH]) ^
           (ref_rob[LSU_ROB_WIDTH-1:0] > rob[LSU_ROB_WIDTH-1:0]);
  endfunction

endpackage

// File: rtl/load_replay_scheduler_select.sv
// Lowest-index picker: one-hot grant plus its binary index.
module replay_select #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  assign gnt = req & (~req + N'(1));
  assign vld = |req;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/load_replay_scheduler.sv
// Parks loads that missed in the data cache and replays each one into its
// issue bank with a single reply pulse once its MSHR refill has arrived.
module load_replay_scheduler
  import load_replay_scheduler_pkg::*;
#(
  parameter int  PIPELINES  = LSU_PIPELINES,
  parameter int  ENTRIES    = 8,
  parameter int  BANK_WIDTH = LSU_BANK_WIDTH,
  parameter int  MSHR_WIDTH = LSU_MSHR_WIDTH,
  parameter int  ROB_WIDTH  = LSU_ROB_WIDTH,
  localparam int ENT_W      = $clog2(ENTRIES),
  localparam int CNT_W      = $clog2(ENTRIES) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [PIPELINES-1:0]                 miss_en,
  input  logic [PIPELINES-1:0][BANK_WIDTH-1:0] miss_issue_idx,
  input  logic [PIPELINES-1:0][MSHR_WIDTH-1:0] miss_mshr,
  input  logic [PIPELINES-1:0][ROB_WIDTH:0]    miss_rob,
  input  logic                                 refill_en,
  input  logic [MSHR_WIDTH-1:0]                refill_mshr,
  input  logic                                 redirect,
  input  logic [ROB_WIDTH:0]                   redirect_rob,
  output logic [PIPELINES-1:0]                 reply_en,
  output logic [PIPELINES-1:0][BANK_WIDTH-1:0] reply_issue_idx,
  output logic                                 full,
  output logic [CNT_W-1:0]                     count
);

  if (PIPELINES != LSU_PIPELINES || BANK_WIDTH != LSU_BANK_WIDTH ||
      MSHR_WIDTH != LSU_MSHR_WIDTH || ROB_WIDTH != LSU_ROB_WIDTH) begin : g_param_check
    $error("load_replay_scheduler widths must match load_replay_scheduler_pkg");
  end

  ReplayEntry                          entry_q [ENTRIES];
  ReplayEntry                          entry_d [ENTRIES];
  logic [ENTRIES-1:0]                  free_vec;
  logic [ENTRIES-1:0]                  wake_vec;
  logic [PIPELINES-1:0][ENTRIES-1:0]   ready_vec;
  logic [PIPELINES-1:0][ENTRIES-1:0]   sel_gnt;
  logic [PIPELINES-1:0][ENT_W-1:0]     sel_idx;
  logic [PIPELINES-1:0]                sel_vld;
  logic [PIPELINES-1:0][ENT_W-1:0]     alloc_idx;
  logic [PIPELINES-1:0]                alloc_vld;

  always_comb begin
    free_vec  = '0;
    wake_vec  = '0;
    ready_vec = '0;
    count     = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      free_vec[i] = (entry_q[i].state == FREE);
      wake_vec[i] = refill_en && (entry_q[i].state == WAIT) && (entry_q[i].mshr == refill_mshr);
      count       = count + CNT_W'(!free_vec[i]);
      for (int p = 0; p < PIPELINES; p++) begin
        ready_vec[p][i] = (entry_q[i].state == READY) && (entry_q[i].bank == LSU_BANK_SEL_W'(p));
      end
    end
  end

  assign full = (ENTRIES - int'(count)) < PIPELINES;

  for (genvar p = 0; p < PIPELINES; p++) begin : g_sel
    replay_select #(.N(ENTRIES)) u_ready_sel (
      .req (ready_vec[p]),
      .gnt (sel_gnt[p]),
      .idx (sel_idx[p]),
      .vld (sel_vld[p])
    );
  end

  // Each pipeline sees the free set minus whatever earlier pipelines claimed.
  for (genvar p = 0; p < PIPELINES; p++) begin : g_alloc
    logic [ENTRIES-1:0] req;
    logic [ENTRIES-1:0] gnt;
    logic [ENTRIES-1:0] taken;
    if (p == 0) begin : g_first
      assign req = free_vec;
    end else begin : g_rest
      assign req = g_alloc[p-1].req & ~g_alloc[p-1].taken;
    end
    assign taken = miss_en[p] ? gnt : '0;
    replay_select #(.N(ENTRIES)) u_free_sel (
      .req (req),
      .gnt (gnt),
      .idx (alloc_idx[p]),
      .vld (alloc_vld[p])
    );
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) entry_d[i] = entry_q[i];
    if (redirect) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!rob_older(entry_q[i].rob, redirect_rob)) entry_d[i].state = FREE;
        else if (wake_vec[i])                         entry_d[i].state = READY;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (wake_vec[i]) entry_d[i].state = READY;
        for (int p = 0; p < PIPELINES; p++) begin
          if (sel_gnt[p][i]) entry_d[i].state = FREE;
        end
      end
      // Refill in the same cycle as the miss parks the load already READY.
      for (int p = 0; p < PIPELINES; p++) begin
        if (miss_en[p] && alloc_vld[p]) begin
          entry_d[alloc_idx[p]].state     = (refill_en && (miss_mshr[p] == refill_mshr)) ? READY : WAIT;
          entry_d[alloc_idx[p]].bank      = LSU_BANK_SEL_W'(p);
          entry_d[alloc_idx[p]].issue_idx = miss_issue_idx[p];
          entry_d[alloc_idx[p]].mshr      = miss_mshr[p];
          entry_d[alloc_idx[p]].rob       = miss_rob[p];
        end
      end
    end
  end

  // Stage boundary: park buffer and registered reply_slow outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) entry_q[i] <= '0;
      reply_en        <= '0;
      reply_issue_idx <= '0;
    end else begin
      entry_q <= entry_d;
      for (int p = 0; p < PIPELINES; p++) begin
        reply_en[p]        <= sel_vld[p] && !redirect;
        reply_issue_idx[p] <= (sel_vld[p] && !redirect) ? entry_q[sel_idx[p]].issue_idx : '0;
      end
    end
  end

endmodule
